softmax_writeback: RTL and testbench

//  Result write-back engine at the output end of the softmax datapath. Captures the
//  NUM-lane result beats (outp0..outp3, qualified by the softmax done strobe), buffers

---
 rtl/softmax_writeback_pkg.sv | 13 +
 rtl/softmax_writeback_if.sv | 10 +
 rtl/wb_fifo.sv | 43 ++++
 rtl/softmax_writeback.sv | 86 ++++++++
 tb/tb_softmax_writeback.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/softmax_writeback_pkg.sv
// softmax_writeback_pkg: shared widths, types and beat packing for the write-back engine
package softmax_writeback_pkg;
    localparam int DATAWIDTH = 16;
    localparam int NUM = 4;
    localparam int ADDRSIZE = 8;
    localparam int WORDW = DATAWIDTH * NUM;
    typedef logic [DATAWIDTH-1:0] lane_t;
    typedef logic [ADDRSIZE-1:0] addr_t;
    typedef logic [WORDW-1:0] word_t;
    function automatic word_t pack_beat(input lane_t l0, input lane_t l1, input lane_t l2, input lane_t l3);
        return {l3, l2, l1, l0};
    endfunction
endpackage

// File: rtl/softmax_writeback_if.sv
// softmax_writeback_if: valid/ready memory write port
interface softmax_writeback_if;
    import softmax_writeback_pkg::*;
    logic wr_en;
    logic wr_ready;
    addr_t wr_addr;
    word_t wr_data;
    modport master(output wr_en, output wr_addr, output wr_data, input wr_ready);
    modport slave(input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous beat FIFO with sync flush and full/empty flags
module wb_fifo
    import softmax_writeback_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW = 3
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  flush,
    input  logic  push,
    input  logic  pop,
    input  word_t wdata,
    output word_t rdata,
    output logic  full,
    output logic  empty
);
    word_t mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic do_push, do_pop;
    assign full = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign rdata = mem[rp];
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= wdata;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop) rp <= rp + AW'(1);
            cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
endmodule

// File: rtl/softmax_writeback.sv
// softmax_writeback: buffers softmax result beats and writes them to memory
// at consecutive addresses from a latched base, with job tracking and error flags.
module softmax_writeback
    import softmax_writeback_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW = 3
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  init,
    input  addr_t wr_start_addr,
    input  addr_t num_beats,
    input  logic  in_valid,
    input  lane_t in0,
    input  lane_t in1,
    input  lane_t in2,
    input  lane_t in3,
    softmax_writeback_if.master wb,
    output logic  busy,
    output logic  wb_done,
    output logic  err_ovf,
    output logic  err_extra
);
    localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, FINISH = 2'd2;
    logic [1:0] state;
    addr_t base, nb, rx_cnt, ld_cnt, wr_cnt;
    logic full, empty, want, room, push, pop, xfer;
    word_t head;
    assign want = in_valid && !init;
    assign room = state == ARMED && rx_cnt < nb;
    assign push = want && room && !full;
    assign pop = !init && !empty && (!wb.wr_en || wb.wr_ready);
    assign xfer = wb.wr_en && wb.wr_ready;
    assign busy = state == ARMED;
    assign wb_done = state == FINISH;
    wb_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
        .clk(clk),
        .reset_n(reset_n),
        .flush(init),
        .push(push),
        .pop(pop),
        .wdata(pack_beat(in0, in1, in2, in3)),
        .rdata(head),
        .full(full),
        .empty(empty)
    );
    // ld_cnt addresses the beat entering the stage; wr_cnt counts accepted writes
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= IDLE;
            base <= '0;
            nb <= '0;
            rx_cnt <= '0;
            ld_cnt <= '0;
            wr_cnt <= '0;
            err_ovf <= 1'b0;
            err_extra <= 1'b0;
            wb.wr_en <= 1'b0;
            wb.wr_addr <= '0;
            wb.wr_data <= '0;
        end else if (init) begin
            state <= num_beats == '0 ? FINISH : ARMED;
            base <= wr_start_addr;
            nb <= num_beats;
            rx_cnt <= '0;
            ld_cnt <= '0;
            wr_cnt <= '0;
            err_ovf <= 1'b0;
            err_extra <= 1'b0;
            wb.wr_en <= 1'b0;
        end else begin
            if (push) rx_cnt <= rx_cnt + addr_t'(1);
            if (want && room && full) err_ovf <= 1'b1;
            if (want && !room) err_extra <= 1'b1;
            if (pop) begin
                wb.wr_en <= 1'b1;
                wb.wr_addr <= base + ld_cnt;
                wb.wr_data <= head;
                ld_cnt <= ld_cnt + addr_t'(1);
            end else if (xfer) wb.wr_en <= 1'b0;
            if (xfer) wr_cnt <= wr_cnt + addr_t'(1);
            state <= state == FINISH ? IDLE
                   : (state == ARMED && xfer && wr_cnt == nb - addr_t'(1)) ? FINISH : state;
        end
endmodule

// File: tb/tb_softmax_writeback.sv
// tb_softmax_writeback: directed checks of beat capture, write-back, stalls and job control
module tb_softmax_writeback;
    import softmax_writeback_pkg::*;
    logic clk = 1'b0;
    logic reset_n, init, in_valid;
    addr_t wr_start_addr, num_beats;
    lane_t in0, in1, in2, in3;
    logic busy, wb_done, err_ovf, err_extra;
    int checks = 0, failures = 0, cyc = 0, done_cnt = 0, done_mark = 0, wbase = 0;
    addr_t wa[$];
    word_t wd[$];
    int ws[$];
    softmax_writeback_if wif();
    softmax_writeback #(.FIFO_DEPTH(8), .FIFO_AW(3)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .init(init),
        .wr_start_addr(wr_start_addr),
        .num_beats(num_beats),
        .in_valid(in_valid),
        .in0(in0),
        .in1(in1),
        .in2(in2),
        .in3(in3),
        .wb(wif),
        .busy(busy),
        .wb_done(wb_done),
        .err_ovf(err_ovf),
        .err_extra(err_extra)
    );
    always #5 clk = ~clk;
    // inputs change just after posedge, so negedge sees what the next edge will sample
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (reset_n && wif.wr_en && wif.wr_ready) begin
            wa.push_back(wif.wr_addr);
            wd.push_back(wif.wr_data);
            ws.push_back(cyc);
        end
        if (wb_done) done_cnt <= done_cnt + 1;
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic word_t ew(input int k);
        return {lane_t'(32'h4000 + k), lane_t'(32'h3000 + k), lane_t'(32'h2000 + k), lane_t'(32'h1000 + k)};
    endfunction
    task automatic send(input int k);
        in_valid = 1'b1;
        in0 = lane_t'(32'h1000 + k);
        in1 = lane_t'(32'h2000 + k);
        in2 = lane_t'(32'h3000 + k);
        in3 = lane_t'(32'h4000 + k);
    endtask
    task automatic idle();
        in_valid = 1'b0;
    endtask
    task automatic mark();
        wbase = wa.size();
        done_mark = done_cnt;
    endtask
    task automatic init_job(input addr_t b, input addr_t n);
        init = 1'b1;
        wr_start_addr = b;
        num_beats = n;
        tick();
        init = 1'b0;
    endtask
    task automatic verify(input string tag, input int n, input addr_t b, input int k0);
        check({tag, "_nwr"}, 64'(wa.size() - wbase), 64'(n));
        for (int i = 0; i < n && wbase + i < wa.size(); i++) begin
            check({tag, "_addr"}, 64'(wa[wbase+i]), 64'(addr_t'(b + addr_t'(i))));
            check({tag, "_data"}, wd[wbase+i], ew(k0 + i));
        end
    endtask
    initial begin
        reset_n = 1'b0;
        init = 1'b0;
        in_valid = 1'b0;
        wr_start_addr = '0;
        num_beats = '0;
        {in0, in1, in2, in3} = '0;
        wif.wr_ready = 1'b0;
        repeat (2) tick();
        check("rst_outs", {wif.wr_en, busy, wb_done, err_ovf, err_extra}, 0);
        check("rst_bus", {wif.wr_addr, wif.wr_data}, 0);
        reset_n = 1'b1;
        tick();
        // basic job, full throughput
        mark();
        wif.wr_ready = 1'b1;
        init_job(8'h10, 8'd4);
        check("t1_busy", busy, 1);
        for (int k = 0; k < 4; k++) begin
            send(k);
            tick();
            if (k == 0) check("t1_lat1", wif.wr_en, 0);
            if (k == 1) check("t1_lat2", {wif.wr_en, wif.wr_addr}, {1'b1, 8'h10});
        end
        idle();
        repeat (2) tick();
        check("t1_done", {wb_done, busy}, 2'b10);
        tick();
        check("t1_idle", {wb_done, busy}, 2'b00);
        verify("t1", 4, 8'h10, 0);
        for (int i = 1; i < 4 && wbase + i < ws.size(); i++)
            check("t1_gap", 64'(ws[wbase+i] - ws[wbase]), 64'(i));
        check("t1_ndone", 64'(done_cnt - done_mark), 1);
        // mid-job stall
        mark();
        init_job(8'h20, 8'd8);
        for (int k = 0; k < 3; k++) begin
            send(k);
            tick();
        end
        wif.wr_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) send(3 + i); else idle();
            tick();
            if (i == 2) check("t2_hold_mid", {wif.wr_en, wif.wr_addr}, {1'b1, 8'h21});
        end
        check("t2_hold_addr", {wif.wr_en, wif.wr_addr}, {1'b1, 8'h21});
        check("t2_hold_data", wif.wr_data, ew(1));
        wif.wr_ready = 1'b1;
        repeat (12) tick();
        verify("t2", 8, 8'h20, 0);
        check("t2_ovf", err_ovf, 0);
        check("t2_ndone", 64'(done_cnt - done_mark), 1);
        // overflow: 9 beats survive (8 buffered + 1 in the stage)
        mark();
        wif.wr_ready = 1'b0;
        init_job(8'h40, 8'd12);
        for (int k = 0; k < 12; k++) begin
            send(k);
            tick();
        end
        idle();
        check("t3_ovf", {err_ovf, err_extra}, 2'b10);
        check("t3_stage", {wif.wr_en, wif.wr_addr}, {1'b1, 8'h40});
        wif.wr_ready = 1'b1;
        repeat (15) tick();
        verify("t3", 9, 8'h40, 0);
        check("t3_busy", busy, 1);
        check("t3_ndone", 64'(done_cnt - done_mark), 0);
        // address wrap
        mark();
        init_job(8'hFE, 8'd4);
        check("t4_clr", err_ovf, 0);
        for (int k = 0; k < 4; k++) begin
            send(k);
            tick();
        end
        idle();
        repeat (6) tick();
        verify("t4", 4, 8'hFE, 0);
        check("t4_ndone", 64'(done_cnt - done_mark), 1);
        // extra beats, zero-length job, init beats in_valid
        mark();
        init_job(8'h50, 8'd2);
        for (int k = 0; k < 3; k++) begin
            send(k);
            tick();
        end
        idle();
        repeat (5) tick();
        verify("t5", 2, 8'h50, 0);
        check("t5_extra", {err_extra, busy}, 2'b10);
        init = 1'b1;
        num_beats = 8'd0;
        send(8);
        tick();
        init = 1'b0;
        idle();
        check("t5_zero", {wb_done, err_extra, wif.wr_en, busy}, 4'b1000);
        tick();
        check("t5_zero_end", wb_done, 0);
        send(9);
        tick();
        idle();
        check("t5_idle_beat", {err_extra, wif.wr_en}, 2'b10);
        check("t5_nwr", 64'(wa.size() - wbase), 2);
        check("t5_ndone", 64'(done_cnt - done_mark), 2);
        // async reset mid-job
        wif.wr_ready = 1'b0;
        init_job(8'h60, 8'd4);
        send(0);
        tick();
        send(1);
        tick();
        idle();
        tick();
        check("t6_pre", wif.wr_en, 1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_outs", {wif.wr_en, busy, wb_done, err_ovf, err_extra}, 0);
        check("t6_rst_bus", {wif.wr_addr, wif.wr_data}, 0);
        tick();
        reset_n = 1'b1;
        tick();
        // re-init while armed flushes buffered beats
        mark();
        init_job(8'h70, 8'd4);
        for (int k = 0; k < 3; k++) begin
            send(k);
            tick();
        end
        idle();
        check("t6_stage", {wif.wr_en, wif.wr_addr}, {1'b1, 8'h70});
        init_job(8'h80, 8'd1);
        check("t6_drop", {wif.wr_en, busy}, 2'b01);
        wif.wr_ready = 1'b1;
        send(9);
        tick();
        idle();
        repeat (5) tick();
        verify("t6", 1, 8'h80, 9);
        check("t6_ndone", 64'(done_cnt - done_mark), 1);
        check("t6_busy", busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
